// File: rtl/uart_pkg.sv
// UART register map and boot loader state encoding.
// The uart_over_axi4lite peripheral uses the same offsets.
package uart_pkg;

  localparam logic [7:0] UART_RX_COUNT_OFS = 8'h00;
  localparam logic [7:0] UART_RX_POP_OFS   = 8'h08;
  localparam logic [7:0] UART_TX_COUNT_OFS = 8'h10;
  localparam logic [7:0] UART_TX_DATA_OFS  = 8'h18;

  typedef enum logic [3:0] {
    BL_IDLE,
    BL_POLL_AR,
    BL_POLL_R,
    BL_WAIT,
    BL_POP_AR,
    BL_POP_R,
    BL_MEM_W,
    BL_MEM_B,
    BL_ACK_W,
    BL_ACK_B
  } boot_state_e;

endpackage

// File: rtl/axil_interface_if.sv
// AXI4-Lite bundle with separate read and write master views.
interface axil_interface_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);

  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic                rvalid;
  logic                rready;

  modport wr_mst (
    output awaddr, awvalid, wdata, wstrb,
    output wvalid, bready,
    input  awready, wready, bvalid
  );

  modport rd_mst (
    output araddr, arvalid, rready,
    input  arready, rdata, rvalid
  );

endinterface

// File: rtl/axil_wr_issue.sv
// Single-outstanding AXI4-Lite write issuer: latches addr/data on req,
// drops AW and W independently, pulses resp_done on the B handshake.
module axil_wr_issue #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       data,
  output logic              accepted,
  output logic              resp_done,
  axil_interface_if.wr_mst  wr
);

  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              pend_q, pend_d;
  logic              aw_hs, w_hs, bready;

  always_comb begin
    aw_hs     = awvalid_q & wr.awready;
    w_hs      = wvalid_q & wr.wready;
    bready    = pend_q & ~awvalid_q & ~wvalid_q;
    resp_done = bready & wr.bvalid;
    // both channels done now or earlier
    accepted  = pend_q & (~awvalid_q | aw_hs)
              & (~wvalid_q | w_hs);
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    pend_d    = pend_q;
    if (req) begin
      awaddr_d  = addr;
      wdata_d   = data;
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      pend_d    = 1'b1;
    end else begin
      if (aw_hs)     awvalid_d = 1'b0;
      if (w_hs)      wvalid_d  = 1'b0;
      if (resp_done) pend_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      pend_q    <= pend_d;
    end
  end

  assign wr.awaddr  = awaddr_q;
  assign wr.awvalid = awvalid_q;
  assign wr.wdata   = wdata_q;
  assign wr.wstrb   = '1;
  assign wr.wvalid  = wvalid_q;
  assign wr.bready  = bready;

endmodule

// File: rtl/uart_boot_loader.sv
// Boot image loader: polls the UART RX FIFO, copies 64-bit words to
// memory, then writes their XOR checksum to the UART TX register.
module uart_boot_loader
  import uart_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] LOAD_BASE  = '0,
  parameter int                LOAD_WORDS = 512,
  parameter logic [ADDR_W-1:0] UART_BASE  = '0,
  parameter int                POLL_GAP   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [15:0]      words_loaded,
  output logic [63:0]      checksum,
  axil_interface_if.rd_mst uart_rd,
  axil_interface_if.wr_mst uart_wr,
  axil_interface_if.wr_mst mem_wr
);

  localparam logic [ADDR_W-1:0] RX_CNT_ADDR =
    UART_BASE + ADDR_W'(UART_RX_COUNT_OFS);
  localparam logic [ADDR_W-1:0] RX_POP_ADDR =
    UART_BASE + ADDR_W'(UART_RX_POP_OFS);
  localparam logic [ADDR_W-1:0] TX_DAT_ADDR =
    UART_BASE + ADDR_W'(UART_TX_DATA_OFS);
  localparam logic [15:0] GAP_INIT = 16'(POLL_GAP - 1);
  localparam logic [16:0] LAST_CNT = 17'(LOAD_WORDS);

  boot_state_e       state_q;
  logic              busy_q, done_q;
  logic              arvalid_q, rready_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [15:0]       words_loaded_q, gap_q;
  logic [63:0]       checksum_q;
  logic [ADDR_W-1:0] mem_addr;
  logic              last_word, mem_req, ack_req;
  logic              mem_acc, mem_done, ack_acc, ack_done;

  assign last_word =
    ({1'b0, words_loaded_q} + 17'd1) == LAST_CNT;
  assign mem_addr =
    LOAD_BASE + ADDR_W'({words_loaded_q, 3'b000});
  assign mem_req = (state_q == BL_POP_R) & uart_rd.rvalid;
  assign ack_req = (state_q == BL_MEM_B) & mem_done & last_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= BL_IDLE;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      arvalid_q      <= 1'b0;
      rready_q       <= 1'b0;
      araddr_q       <= '0;
      words_loaded_q <= '0;
      gap_q          <= '0;
      checksum_q     <= '0;
    end else begin
      unique case (state_q)
        BL_IDLE: if (start) begin
          busy_q         <= 1'b1;
          done_q         <= 1'b0;
          words_loaded_q <= '0;
          checksum_q     <= '0;
          arvalid_q      <= 1'b1;
          araddr_q       <= RX_CNT_ADDR;
          state_q        <= BL_POLL_AR;
        end
        BL_POLL_AR, BL_POP_AR: if (uart_rd.arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state_q   <= (state_q == BL_POLL_AR) ?
                       BL_POLL_R : BL_POP_R;
        end
        BL_POLL_R: if (uart_rd.rvalid) begin
          rready_q <= 1'b0;
          if (uart_rd.rdata >= 64'd8) begin
            arvalid_q <= 1'b1;
            araddr_q  <= RX_POP_ADDR;
            state_q   <= BL_POP_AR;
          end else begin
            gap_q   <= GAP_INIT;
            state_q <= BL_WAIT;
          end
        end
        BL_WAIT: if (gap_q == '0) begin
          arvalid_q <= 1'b1;
          araddr_q  <= RX_CNT_ADDR;
          state_q   <= BL_POLL_AR;
        end else begin
          gap_q <= gap_q - 16'd1;
        end
        BL_POP_R: if (uart_rd.rvalid) begin
          rready_q   <= 1'b0;
          checksum_q <= checksum_q ^ uart_rd.rdata;
          state_q    <= BL_MEM_W;
        end
        BL_MEM_W: if (mem_acc) state_q <= BL_MEM_B;
        BL_MEM_B: if (mem_done) begin
          if (words_loaded_q != 16'hFFFF)
            words_loaded_q <= words_loaded_q + 16'd1;
          if (last_word) begin
            state_q <= BL_ACK_W;
          end else begin
            arvalid_q <= 1'b1;
            araddr_q  <= RX_CNT_ADDR;
            state_q   <= BL_POLL_AR;
          end
        end
        BL_ACK_W: if (ack_acc) state_q <= BL_ACK_B;
        BL_ACK_B: if (ack_done) begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= BL_IDLE;
        end
        default: state_q <= BL_IDLE;
      endcase
    end
  end

  axil_wr_issue #(.ADDR_W(ADDR_W)) u_mem_wr (
    .clk       (clk),
    .rst       (rst),
    .req       (mem_req),
    .addr      (mem_addr),
    .data      (uart_rd.rdata),
    .accepted  (mem_acc),
    .resp_done (mem_done),
    .wr        (mem_wr)
  );

  axil_wr_issue #(.ADDR_W(ADDR_W)) u_uart_wr (
    .clk       (clk),
    .rst       (rst),
    .req       (ack_req),
    .addr      (TX_DAT_ADDR),
    .data      (checksum_q),
    .accepted  (ack_acc),
    .resp_done (ack_done),
    .wr        (uart_wr)
  );

  assign uart_rd.arvalid = arvalid_q;
  assign uart_rd.araddr  = araddr_q;
  assign uart_rd.rready  = rready_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign words_loaded    = words_loaded_q;
  assign checksum        = checksum_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader with UART and memory slave models.
module tb_uart_boot_loader;
  import uart_pkg::*;

  localparam int GAP = 4;
  localparam logic [31:0] UB  = 32'h4000_0000;
  localparam logic [31:0] RXC = UB + 32'(UART_RX_COUNT_OFS);
  localparam logic [31:0] POP = UB + 32'(UART_RX_POP_OFS);
  localparam logic [31:0] TXA = UB + 32'(UART_TX_DATA_OFS);
  localparam logic [63:0] W0  = 64'h0807060504030201;
  localparam logic [63:0] W1  = 64'h100F0E0D0C0B0A09;
  localparam logic [63:0] CKS = 64'h1808080808080808;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done;
  logic [15:0] words_loaded;
  logic [63:0] checksum;

  always #5 clk = ~clk;

  axil_interface_if #(.ADDR_W(32)) urd ();
  axil_interface_if #(.ADDR_W(32)) uwr ();
  axil_interface_if #(.ADDR_W(32)) mwr ();

  uart_boot_loader #(
    .ADDR_W(32), .LOAD_BASE(32'h0), .LOAD_WORDS(2),
    .UART_BASE(UB), .POLL_GAP(GAP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .done(done), .words_loaded(words_loaded),
    .checksum(checksum), .uart_rd(urd), .uart_wr(uwr),
    .mem_wr(mwr)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string why);
    tests++;
    fails++;
    $display("FAIL %s: %s", name, why);
  endtask

  // scoreboard queues
  logic [31:0] exp_maddr[$];
  logic [63:0] exp_mdata[$];
  logic [63:0] exp_tx[$];
  int          exp_polls[$];

  // UART read slave
  logic [7:0]  rx_q[$];
  int          cnt_script[$];
  logic        rv = 1'b0;
  logic [63:0] rd = '0;
  assign urd.arready = 1'b1;
  assign urd.rvalid  = rv;
  assign urd.rdata   = rd;

  function automatic logic [63:0] pop_word();
    logic [63:0] w = '0;
    for (int i = 0; i < 8; i++)
      if (rx_q.size() != 0) w[8*i +: 8] = rx_q.pop_front();
    return w;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      rv <= 1'b0;
    end else begin
      if (rv && urd.rready) rv <= 1'b0;
      if (urd.arvalid) begin
        rv <= 1'b1;
        if (urd.araddr == RXC)
          rd <= (cnt_script.size() != 0) ?
                64'(cnt_script.pop_front()) : 64'(rx_q.size());
        else if (urd.araddr == POP)
          rd <= pop_word();
        else
          rd <= '0;
      end
    end
  end

  // memory write slave
  int m_aw_hold = 0, m_w_hold = 0;
  int m_aw_wait = 0, m_w_wait = 0, m_aw_n = 0;
  logic m_awg = 1'b0, m_wg = 1'b0, m_bv = 1'b0;
  logic [31:0] m_addr = '0;
  logic [63:0] m_data = '0;
  logic m_aw_hs, m_w_hs;
  assign mwr.awready = (m_aw_wait >= m_aw_hold);
  assign mwr.wready  = (m_w_wait >= m_w_hold);
  assign mwr.bvalid  = m_bv;
  assign m_aw_hs = mwr.awvalid && mwr.awready;
  assign m_w_hs  = mwr.wvalid && mwr.wready;

  always @(posedge clk) begin
    if (rst) begin
      m_aw_wait <= 0; m_w_wait <= 0;
      m_awg <= 1'b0; m_wg <= 1'b0; m_bv <= 1'b0;
    end else begin
      m_aw_wait <= (mwr.awvalid && !m_aw_hs) ? m_aw_wait + 1 : 0;
      m_w_wait  <= (mwr.wvalid && !m_w_hs) ? m_w_wait + 1 : 0;
      if (m_aw_hs) begin
        m_addr <= mwr.awaddr;
        m_aw_n <= m_aw_n + 1;
      end
      if (m_w_hs) m_data <= mwr.wdata;
      if (m_bv) begin
        if (mwr.bready) m_bv <= 1'b0;
      end else if ((m_awg || m_aw_hs) && (m_wg || m_w_hs)) begin
        m_bv <= 1'b1; m_awg <= 1'b0; m_wg <= 1'b0;
      end else begin
        m_awg <= m_awg || m_aw_hs;
        m_wg  <= m_wg || m_w_hs;
      end
    end
  end

  // UART TX write slave
  int t_w_hold = 0, t_w_wait = 0;
  logic t_awg = 1'b0, t_wg = 1'b0, t_bv = 1'b0;
  logic [31:0] t_addr = '0;
  logic [63:0] t_data = '0;
  logic t_aw_hs, t_w_hs;
  assign uwr.awready = 1'b1;
  assign uwr.wready  = (t_w_wait >= t_w_hold);
  assign uwr.bvalid  = t_bv;
  assign t_aw_hs = uwr.awvalid && uwr.awready;
  assign t_w_hs  = uwr.wvalid && uwr.wready;

  always @(posedge clk) begin
    if (rst) begin
      t_w_wait <= 0;
      t_awg <= 1'b0; t_wg <= 1'b0; t_bv <= 1'b0;
    end else begin
      t_w_wait <= (uwr.wvalid && !t_w_hs) ? t_w_wait + 1 : 0;
      if (t_aw_hs) t_addr <= uwr.awaddr;
      if (t_w_hs) t_data <= uwr.wdata;
      if (t_bv) begin
        if (uwr.bready) t_bv <= 1'b0;
      end else if ((t_awg || t_aw_hs) && (t_wg || t_w_hs)) begin
        t_bv <= 1'b1; t_awg <= 1'b0; t_wg <= 1'b0;
      end else begin
        t_awg <= t_awg || t_aw_hs;
        t_wg  <= t_wg || t_w_hs;
      end
    end
  end

  // monitor: samples on the falling edge
  int   polls = 0, last_poll = 0, m_b_n = 0;
  bit   gap_ok = 0, lat_on = 0, w_first = 0;
  logic p_rst = 1'b1;
  logic pm_awv = 0, pm_awr = 0, pm_wv = 0, pm_wr = 0;
  logic pt_wv = 0, pt_wr = 0;
  logic [31:0] pm_awaddr = '0;
  logic [63:0] pm_wdata = '0, pt_wdata = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (urd.arvalid && urd.arready && urd.araddr == RXC) begin
        if (gap_ok) chk("poll_gap", 64'(cyc - last_poll), GAP + 2);
        last_poll = cyc;
        gap_ok = 1;
        polls++;
      end
      if (urd.arvalid && urd.arready && urd.araddr == POP) begin
        if (exp_polls.size() == 0)
          fail_now("pop", "pop seen, none required");
        else
          chk("polls_before_pop", 64'(polls), 64'(exp_polls.pop_front()));
        polls = 0;
        gap_ok = 0;
      end
      if (mwr.wvalid && mwr.wready)
        chk("mem_wstrb", 64'(mwr.wstrb), 64'hFF);
      if (mwr.awvalid && !mwr.wvalid) w_first = 1;
      if (mwr.bvalid && mwr.bready) begin
        m_b_n++;
        if (exp_maddr.size() == 0) begin
          fail_now("mem_write", "write seen, none required");
        end else begin
          chk("mem_addr", 64'(m_addr), 64'(exp_maddr.pop_front()));
          chk("mem_data", m_data, exp_mdata.pop_front());
        end
        if (lat_on) chk("word_latency", 64'(cyc - last_poll), 5);
      end
      if (uwr.bvalid && uwr.bready) begin
        chk("done_before_tx_b", 64'(done), 0);
        if (exp_tx.size() == 0) begin
          fail_now("tx_write", "write seen, none required");
        end else begin
          chk("tx_addr", 64'(t_addr), 64'(TXA));
          chk("tx_data", t_data, exp_tx.pop_front());
        end
      end
      if (!p_rst && pm_awv && !pm_awr) begin
        chk("mem_awvalid_hold", 64'(mwr.awvalid), 1);
        chk("mem_awaddr_hold", 64'(mwr.awaddr), 64'(pm_awaddr));
      end
      if (!p_rst && pm_wv && !pm_wr) begin
        chk("mem_wvalid_hold", 64'(mwr.wvalid), 1);
        chk("mem_wdata_hold", mwr.wdata, pm_wdata);
      end
      if (!p_rst && pt_wv && !pt_wr) begin
        chk("tx_wvalid_hold", 64'(uwr.wvalid), 1);
        chk("tx_wdata_hold", uwr.wdata, pt_wdata);
        chk("tx_stall_done", 64'(done), 0);
      end
    end else begin
      polls = 0;
      gap_ok = 0;
    end
    p_rst = rst;
    pm_awv = mwr.awvalid; pm_awr = mwr.awready;
    pm_awaddr = mwr.awaddr;
    pm_wv = mwr.wvalid; pm_wr = mwr.wready;
    pm_wdata = mwr.wdata;
    pt_wv = uwr.wvalid; pt_wr = uwr.wready;
    pt_wdata = uwr.wdata;
  end

  function automatic bit cond(input int which);
    case (which)
      0:       return done;
      1:       return m_b_n >= 1;
      2:       return uwr.wvalid;
      default: return mwr.awvalid;
    endcase
  endfunction

  task automatic wait_for(input int which, input string name);
    int n = 0;
    while (!cond(which) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!cond(which)) fail_now(name, "timeout after 3000 cycles");
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic load_bytes(input logic [7:0] base);
    for (int i = 0; i < 16; i++) rx_q.push_back(base + 8'(i));
  endtask

  task automatic push_two_words();
    exp_maddr.push_back(32'h0); exp_mdata.push_back(W0);
    exp_maddr.push_back(32'h8); exp_mdata.push_back(W1);
    exp_tx.push_back(CKS);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_words", 64'(words_loaded), 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_handshake", 64'({urd.arvalid, urd.rready, mwr.awvalid,
        mwr.wvalid, mwr.bready, uwr.awvalid, uwr.wvalid,
        uwr.bready}), 0);

    // load with slow RX fill, memory stall and TX backpressure
    load_bytes(8'h01);
    cnt_script = '{0, 0, 7};
    exp_polls.push_back(4);
    exp_polls.push_back(1);
    push_two_words();
    m_aw_hold = 5; m_w_hold = 2; t_w_hold = 20;
    pulse_start();
    @(negedge clk);
    chk("busy_after_start", 64'(busy), 1);
    wait_for(1, "first_mem_write");
    m_aw_hold = 0; m_w_hold = 0;
    chk("w_drops_before_aw", 64'(w_first), 1);
    wait_for(2, "tx_wvalid");
    repeat (3) @(negedge clk);
    pulse_start();
    @(negedge clk);
    chk("busy_start_words", 64'(words_loaded), 2);
    chk("busy_start_checksum", checksum, CKS);
    chk("busy_start_busy", 64'(busy), 1);
    wait_for(0, "done_a");
    @(negedge clk);
    chk("a_done", 64'(done), 1);
    chk("a_busy", 64'(busy), 0);
    chk("a_words", 64'(words_loaded), 2);
    chk("a_checksum", checksum, CKS);

    // reset while stalled in the memory write
    load_bytes(8'hA1);
    exp_polls.push_back(1);
    m_aw_hold = 1000;
    pulse_start();
    @(negedge clk);
    chk("done_cleared", 64'(done), 0);
    wait_for(3, "mem_awvalid");
    @(posedge clk); #1 rst = 1'b1; start = 1'b1;
    @(posedge clk); #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_mid_valids", 64'({urd.arvalid, urd.rready,
        mwr.awvalid, mwr.wvalid, mwr.bready, uwr.awvalid,
        uwr.wvalid, uwr.bready}), 0);
    chk("rst_mid_busy", 64'(busy), 0);
    chk("rst_mid_checksum", checksum, 0);

    // reload from LOAD_BASE with zero-wait memory
    rx_q.delete();
    load_bytes(8'h01);
    m_aw_hold = 0;
    exp_polls.push_back(1);
    exp_polls.push_back(1);
    push_two_words();
    lat_on = 1;
    pulse_start();
    wait_for(0, "done_b");
    @(negedge clk);
    chk("b_done", 64'(done), 1);
    chk("b_busy", 64'(busy), 0);
    chk("b_words", 64'(words_loaded), 2);
    chk("b_checksum", checksum, CKS);
    chk("mem_aw_count", 64'(m_aw_n), 4);
    chk("mem_exp_left", 64'(exp_maddr.size()), 0);
    chk("tx_exp_left", 64'(exp_tx.size()), 0);
    chk("poll_exp_left", 64'(exp_polls.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
